// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: control bundle, register-number width and the NOP encoding.
package mips_pkg;

  localparam int unsigned RegAddrW = 5;
  localparam logic [31:0] NopInstr = 32'h0000_0000;

  typedef logic [RegAddrW-1:0] reg_addr_t;

  // Decoded control word carried from decode into execute (8 bits, RegWrite is the MSB).
  typedef struct packed {
    logic       RegWrite;
    logic       MemtoReg;
    logic       MemWrite;
    logic       ALUSrc;
    logic       RegDst;
    logic [2:0] ALUControl;
  } ctrl_t;

endpackage

// File: rtl/pipe_regs_if.sv
// Bundle of hazard controls, stage inputs and stage-register outputs of the pipeline registers.
interface pipe_regs_if #(
  parameter int unsigned WIDTH = 32
) ();
  import mips_pkg::*;

  // Hazard-unit controls
  logic             StallF, StallD, FlushD, FlushE;
  // Stage inputs
  logic [WIDTH-1:0] PCNextF, InstrF, PCPlus4F;
  ctrl_t            ctrlD;
  logic [WIDTH-1:0] RD1D, RD2D, SignImmD;
  logic [WIDTH-1:0] ALUOutE, WriteDataE, ReadDataM;
  // Fetch / decode outputs
  logic [WIDTH-1:0] PCF, InstrD, PCPlus4D;
  reg_addr_t        rsD, rtD, rdD;
  // Execute outputs
  reg_addr_t        rsE, rtE, rdE, WriteRegE;
  ctrl_t            ctrlE;
  logic [WIDTH-1:0] RD1E, RD2E, SignImmE;
  logic             RegWriteE, MemtoRegE;
  // Memory outputs
  reg_addr_t        WriteRegM;
  logic             RegWriteM, MemtoRegM, MemWriteM;
  logic [WIDTH-1:0] ALUOutM, WriteDataM;
  // Writeback outputs
  reg_addr_t        WriteRegW;
  logic             RegWriteW, MemtoRegW;
  logic [WIDTH-1:0] ALUOutW, ReadDataW, ResultW;
  logic [31:0]      retired;

  modport master (
    output StallF, StallD, FlushD, FlushE, PCNextF, InstrF, PCPlus4F, ctrlD, RD1D, RD2D,
           SignImmD, ALUOutE, WriteDataE, ReadDataM,
    input  PCF, InstrD, PCPlus4D, rsD, rtD, rdD, rsE, rtE, rdE, WriteRegE, ctrlE, RD1E, RD2E,
           SignImmE, RegWriteE, MemtoRegE, WriteRegM, RegWriteM, MemtoRegM, MemWriteM, ALUOutM,
           WriteDataM, WriteRegW, RegWriteW, MemtoRegW, ALUOutW, ReadDataW, ResultW, retired
  );

  modport slave (
    input  StallF, StallD, FlushD, FlushE, PCNextF, InstrF, PCPlus4F, ctrlD, RD1D, RD2D,
           SignImmD, ALUOutE, WriteDataE, ReadDataM,
    output PCF, InstrD, PCPlus4D, rsD, rtD, rdD, rsE, rtE, rdE, WriteRegE, ctrlE, RD1E, RD2E,
           SignImmE, RegWriteE, MemtoRegE, WriteRegM, RegWriteM, MemtoRegM, MemWriteM, ALUOutM,
           WriteDataM, WriteRegW, RegWriteW, MemtoRegW, ALUOutW, ReadDataW, ResultW, retired
  );

endinterface

// File: rtl/pipe_regs_flopenrc.sv
// Generic stage register: synchronous reset, enable, and synchronous clear gated by enable.
module flopenrc #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] q_q;

  // Reset wins; a clear only lands when the register is enabled, so a held stage is never wiped.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= clr_i ? '0 : d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/pipe_regs.sv
// Five-stage MIPS pipeline registers (F, D, E, M, W) with stall/flush and a retire counter.
module pipe_regs import mips_pkg::*; #(
  parameter int unsigned WIDTH = 32
) (
  input logic        clk,
  input logic        reset,
  pipe_regs_if.slave bus
);

  localparam int unsigned DecW = 2 * WIDTH + 1;
  localparam int unsigned ExeW = $bits(ctrl_t) + 3 * RegAddrW + 3 * WIDTH + 1;
  localparam int unsigned MemW = 3 + RegAddrW + 2 * WIDTH + 1;
  localparam int unsigned WbW  = 2 + RegAddrW + 2 * WIDTH + 1;

  // Fetch
  logic [WIDTH-1:0] pc_q;
  // Decode
  logic [DecW-1:0]  dec_d, dec_q;
  logic [WIDTH-1:0] instr_dec, pc_plus4_dec;
  logic             valid_dec;
  reg_addr_t        rs_dec, rt_dec, rd_dec;
  // Execute
  logic [ExeW-1:0]  exe_d, exe_q;
  ctrl_t            ctrl_exe;
  reg_addr_t        rs_exe, rt_exe, rd_exe, write_reg_exe;
  logic [WIDTH-1:0] rd1_exe, rd2_exe, sign_imm_exe;
  logic             valid_exe;
  // Memory
  logic [MemW-1:0]  mem_d, mem_q;
  logic             reg_write_mem, memto_reg_mem, mem_write_mem, valid_mem;
  reg_addr_t        write_reg_mem;
  logic [WIDTH-1:0] alu_out_mem, write_data_mem;
  // Writeback
  logic [WbW-1:0]   wb_d, wb_q;
  logic             reg_write_wb, memto_reg_wb, valid_wb;
  reg_addr_t        write_reg_wb;
  logic [WIDTH-1:0] alu_out_wb, read_data_wb;
  // Retire counter
  logic [31:0]      retired_d, retired_q;

  // ---------------- F ----------------
  flopenrc #(.Width(WIDTH)) u_f_reg (
    .clk   (clk),
    .reset (reset),
    .en_i  (~bus.StallF),
    .clr_i (1'b0),
    .d_i   (bus.PCNextF),
    .q_o   (pc_q)
  );

  // ---------------- D ----------------
  // Holding the register (enable low) also masks FlushD, giving stall priority over flush.
  assign dec_d = {bus.InstrF, bus.PCPlus4F, 1'b1};

  flopenrc #(.Width(DecW)) u_d_reg (
    .clk   (clk),
    .reset (reset),
    .en_i  (~bus.StallD),
    .clr_i (bus.FlushD),
    .d_i   (dec_d),
    .q_o   (dec_q)
  );

  assign {instr_dec, pc_plus4_dec, valid_dec} = dec_q;
  assign rs_dec = instr_dec[25:21];
  assign rt_dec = instr_dec[20:16];
  assign rd_dec = instr_dec[15:11];

  // ---------------- E ----------------
  // FlushE turns the incoming slot into a bubble: zero control, zero fields, not valid.
  assign exe_d = {bus.ctrlD, rs_dec, rt_dec, rd_dec, bus.RD1D, bus.RD2D, bus.SignImmD, valid_dec};

  flopenrc #(.Width(ExeW)) u_e_reg (
    .clk   (clk),
    .reset (reset),
    .en_i  (1'b1),
    .clr_i (bus.FlushE),
    .d_i   (exe_d),
    .q_o   (exe_q)
  );

  assign {ctrl_exe, rs_exe, rt_exe, rd_exe, rd1_exe, rd2_exe, sign_imm_exe, valid_exe} = exe_q;
  assign write_reg_exe = ctrl_exe.RegDst ? rd_exe : rt_exe;

  // ---------------- M ----------------
  assign mem_d = {ctrl_exe.RegWrite, ctrl_exe.MemtoReg, ctrl_exe.MemWrite, write_reg_exe,
                  bus.ALUOutE, bus.WriteDataE, valid_exe};

  flopenrc #(.Width(MemW)) u_m_reg (
    .clk   (clk),
    .reset (reset),
    .en_i  (1'b1),
    .clr_i (1'b0),
    .d_i   (mem_d),
    .q_o   (mem_q)
  );

  assign {reg_write_mem, memto_reg_mem, mem_write_mem, write_reg_mem, alu_out_mem,
          write_data_mem, valid_mem} = mem_q;

  // ---------------- W ----------------
  assign wb_d = {reg_write_mem, memto_reg_mem, write_reg_mem, alu_out_mem, bus.ReadDataM,
                 valid_mem};

  flopenrc #(.Width(WbW)) u_w_reg (
    .clk   (clk),
    .reset (reset),
    .en_i  (1'b1),
    .clr_i (1'b0),
    .d_i   (wb_d),
    .q_o   (wb_q)
  );

  assign {reg_write_wb, memto_reg_wb, write_reg_wb, alu_out_wb, read_data_wb, valid_wb} = wb_q;

  // ---------------- Retire counter ----------------
  // Counts only valid slots leaving W; bubbles and flushed slots never retire. Wraps naturally.
  assign retired_d = retired_q + 32'd1;

  flopenrc #(.Width(32)) u_retired (
    .clk   (clk),
    .reset (reset),
    .en_i  (valid_wb),
    .clr_i (1'b0),
    .d_i   (retired_d),
    .q_o   (retired_q)
  );

  // ---------------- Outputs ----------------
  assign bus.PCF        = pc_q;
  assign bus.InstrD     = instr_dec;
  assign bus.PCPlus4D   = pc_plus4_dec;
  assign bus.rsD        = rs_dec;
  assign bus.rtD        = rt_dec;
  assign bus.rdD        = rd_dec;
  assign bus.ctrlE      = ctrl_exe;
  assign bus.rsE        = rs_exe;
  assign bus.rtE        = rt_exe;
  assign bus.rdE        = rd_exe;
  assign bus.WriteRegE  = write_reg_exe;
  assign bus.RD1E       = rd1_exe;
  assign bus.RD2E       = rd2_exe;
  assign bus.SignImmE   = sign_imm_exe;
  assign bus.RegWriteE  = ctrl_exe.RegWrite;
  assign bus.MemtoRegE  = ctrl_exe.MemtoReg;
  assign bus.WriteRegM  = write_reg_mem;
  assign bus.RegWriteM  = reg_write_mem;
  assign bus.MemtoRegM  = memto_reg_mem;
  assign bus.MemWriteM  = mem_write_mem;
  assign bus.ALUOutM    = alu_out_mem;
  assign bus.WriteDataM = write_data_mem;
  assign bus.WriteRegW  = write_reg_wb;
  assign bus.RegWriteW  = reg_write_wb;
  assign bus.MemtoRegW  = memto_reg_wb;
  assign bus.ALUOutW    = alu_out_wb;
  assign bus.ReadDataW  = read_data_wb;
  assign bus.ResultW    = memto_reg_wb ? read_data_wb : alu_out_wb;
  assign bus.retired    = retired_q;

endmodule

// File: doc/pipe_regs.md
PIPE_REGS -- requirements
Module: pipe_regs

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath word width for PC, instruction and data fields.
REQ-002 SHALL have port clk  input  1  single pipeline clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports StallF, StallD, FlushE  input  1 each  hazard-unit controls.
REQ-005 SHALL have port FlushD  input  1  taken branch/bne resolved in decode; kills the fetched instruction.
REQ-006 SHALL have ports PCNextF, InstrF, PCPlus4F  input  WIDTH each  fetch-stage values.
REQ-007 SHALL have ports ctrlD  input  ctrl_t (8 bits: RegWrite, MemtoReg, MemWrite, ALUSrc, RegDst, ALUControl[2:0]); RD1D, RD2D, SignImmD  input  WIDTH each.
REQ-008 SHALL have ports ALUOutE, WriteDataE  input  WIDTH; ReadDataM  input  WIDTH.
REQ-009 SHALL have outputs PCF, InstrD, PCPlus4D  WIDTH; rsD, rtD, rdD  5  (InstrD[25:21], [20:16], [15:11]).
REQ-010 SHALL have outputs rsE, rtE, rdE, WriteRegE  5; ctrlE  ctrl_t; RD1E, RD2E, SignImmE  WIDTH; RegWriteE, MemtoRegE  1.
REQ-011 SHALL have outputs WriteRegM  5; RegWriteM, MemtoRegM, MemWriteM  1; ALUOutM, WriteDataM  WIDTH.
REQ-012 SHALL have outputs WriteRegW  5; RegWriteW, MemtoRegW  1; ALUOutW, ReadDataW  WIDTH; ResultW  WIDTH.
REQ-013 SHALL have output retired  32  count of valid instructions leaving W.

Function
REQ-014 PCF SHALL load PCNextF each edge unless StallF=1, then hold.
REQ-015 D register (InstrD, PCPlus4D, validD) SHALL hold when StallD=1; else if FlushD=1 load zeros (NOP, validD=0); else load fetch values with validD=1.
REQ-016 StallD SHALL take priority over FlushD (a stalled D is never flushed in the same cycle).
REQ-017 E register SHALL load D-stage fields each edge; when FlushE=1 it SHALL load ctrlE=0, rsE=rtE=rdE=0, validE=0 (bubble), data fields don't-care zero.
REQ-018 StallD=1 with FlushE=1 (load-use / branch stall) SHALL hold D and insert exactly one bubble in E per cycle asserted.
REQ-019 WriteRegE SHALL be combinational: rdE if ctrlE.RegDst else rtE; RegWriteE/MemtoRegE SHALL be ctrlE fields.
REQ-020 M and W registers SHALL advance unconditionally every cycle (never stalled or flushed); validM/validW follow.
REQ-021 ResultW SHALL be ReadDataW when MemtoRegW else ALUOutW (combinational).
REQ-022 retired SHALL increment by 1 on each edge where validW=1; wraps 32'hFFFF_FFFF -> 0.
REQ-023 Latency: an unstalled instruction SHALL appear in D, E, M, W on successive edges, 1 cycle per stage.

Reset
REQ-024 reset=1 at an edge SHALL zero every register: PCF=0, all stage fields/ctrl=0, all valid bits=0, retired=0; reset overrides stall and flush.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight instructions; no write-enable (RegWriteW, MemWriteM) asserted in the cycle after reset.

Structure
REQ-026 ctrl_t packed struct, NOP instruction constant 32'h0000_0000 and register-number width SHALL live in shared package mips_pkg.
REQ-027 Every stage register SHALL be built from one sub-module flopenrc (parameterized width; sync reset, enable, sync clear; clear effective only when enabled).

Verification
REQ-028 Straight-line: 4 instructions, no stall/flush -> each reaches W 4 edges after fetch; retired=4 after drain.
REQ-029 Load-use: StallF=StallD=FlushE=1 for one cycle with InstrD=32'h8C08_0004 -> PCF and InstrD held, ctrlE=0, validE=0; next cycle instruction enters E.
REQ-030 Branch taken: FlushD=1, StallD=0 -> InstrD=0 next cycle, retired not incremented for killed slot.
REQ-031 Stall+flush conflict: StallD=1, FlushD=1 -> InstrD unchanged.
REQ-032 Reset mid-stream: reset pulse with 3 valid instructions in flight -> all outputs 0, RegWriteW=0, retired=0 next cycle.
REQ-033 Counter wrap: preload retired to 32'hFFFF_FFFF via forcing, one valid W -> retired=0.
